// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchroniser, bit-timing FSM and a small show-ahead FIFO.
module uart_rx #(
  parameter int unsigned CLK_HZ       = 12000000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned CLKS_PER_BIT = CLK_HZ / BAUD,
  parameter int unsigned DEPTH        = 4
) (
  input  logic       sys_clk_i,
  input  logic       sys_rst_i,
  input  logic       uart_rx_i,
  output logic [7:0] uart_dat_o,
  output logic       uart_valid_o,
  input  logic       uart_rd_i,
  output logic       uart_frame_err_o,
  output logic       uart_overrun_o,
  input  logic       uart_err_clr_i,
  output logic       uart_busy_o
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PW    = AW + 1;

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             frame_err_q, frame_err_d;
  logic             push_c;

  logic             rx_meta, rx_s;

  logic [7:0]       mem [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic             overrun_q;
  logic             empty_c, full_c, pop_c, wr_c, drop_c;

  // Two-stage synchroniser for the asynchronous line; idles high.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= uart_rx_i;
      rx_s    <= rx_meta;
    end
  end

  // Receiver state, bit timer, bit index, shift register and error pulse.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Next-state logic; the timer restarts on every state entry and after each data bit.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    bit_d       = bit_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    push_c      = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            bit_d   = '0;
          end
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'(1);
          if (bit_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_M1) begin
          cnt_d = '0;
          if (rx_s) begin
            push_c  = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // FIFO flags; a pop in the same cycle frees the slot a full-FIFO push needs.
  always_comb begin
    empty_c = (wptr_q == rptr_q);
    full_c  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    pop_c   = uart_rd_i && !empty_c;
    wr_c    = push_c && (!full_c || pop_c);
    drop_c  = push_c && full_c && !pop_c;
  end

  // FIFO storage, pointers and sticky overrun flag (a new overrun beats a clear).
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      overrun_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_c) begin
        mem[wptr_q[AW-1:0]] <= shift_q;
        wptr_q              <= wptr_q + PW'(1);
      end
      if (pop_c) rptr_q <= rptr_q + PW'(1);
      if (drop_c) overrun_q <= 1'b1;
      else if (uart_err_clr_i) overrun_q <= 1'b0;
    end
  end

  assign uart_dat_o       = mem[rptr_q[AW-1:0]];
  assign uart_valid_o     = !empty_c;
  assign uart_frame_err_o = frame_err_q;
  assign uart_overrun_o   = overrun_q;
  assign uart_busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frames driven on the line, byte queue model of the FIFO.
module tb_uart_rx;

  localparam int CPB   = 104;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] dat;
  logic       valid;
  logic       rd;
  logic       ferr;
  logic       ovr;
  logic       clr;
  logic       busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int err_pulses = 0;

  logic [7:0] model_q[$];
  logic       model_ovf = 1'b0;

  uart_rx #(.CLK_HZ(12000000), .BAUD(115200), .CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .sys_clk_i       (clk),
    .sys_rst_i       (rst),
    .uart_rx_i       (rx),
    .uart_dat_o      (dat),
    .uart_valid_o    (valid),
    .uart_rd_i       (rd),
    .uart_frame_err_o(ferr),
    .uart_overrun_o  (ovr),
    .uart_err_clr_i  (clr),
    .uart_busy_o     (busy)
  );

  always #5 clk = ~clk;

  // Count error pulses seen on the line over the whole run.
  always @(posedge clk) if (ferr) err_pulses <= err_pulses + 1;

  // One bit period on the line; entered and left #1 after a clock edge.
  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // Start bit, 8 data bits LSB first, stop bit. The start bit goes low #1 after edge P0.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    @(posedge clk);
    #1;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  // Reference FIFO: a byte is kept if there is room, or if a pop frees the head in the same cycle.
  task automatic model_rx(input logic [7:0] b, input logic pop_same);
    if (model_q.size() >= DEPTH && !pop_same) begin
      model_ovf = 1'b1;
    end else begin
      if (pop_same && model_q.size() > 0) void'(model_q.pop_front());
      model_q.push_back(b);
    end
  endtask

  task automatic pop_one();
    rd = 1'b1;
    @(posedge clk);
    #1;
    rd = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b1; rd = 1'b0; clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", valid); end
    n_cmp++; if (dat !== 8'h00) begin n_fail++; $display("FAIL reset_dat: got %02h want 00", dat); end
    n_cmp++; if (ferr !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %0b want 0", ferr); end
    n_cmp++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %0b want 0", ovr); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %0b want 0", busy); end
  endtask

  // Start goes low at P0; the stop sample registers at P3+988, so the byte shows after P991.
  task automatic test_basic();
    int e0;
    e0 = err_pulses;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        @(posedge clk);
        repeat (990) @(posedge clk);
        #1;
        n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %0b want 0", valid); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_stop: got %0b want 1", busy); end
        @(posedge clk);
        #1;
        n_cmp++; if (valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %0b want 1", valid); end
        n_cmp++; if (dat !== 8'hA5) begin n_fail++; $display("FAIL basic_dat: got %02h want a5", dat); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after: got %0b want 0", busy); end
      end
    join
    n_cmp++; if (err_pulses - e0 !== 0) begin n_fail++; $display("FAIL basic_ferr_count: got %0d want 0", err_pulses - e0); end
    pop_one();
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL basic_drained: got %0b want 0", valid); end
  endtask

  // 20-cycle low pulse: START entered at P3, aborts on the mid-bit sample and is IDLE after P55.
  task automatic test_glitch();
    int e0;
    e0 = err_pulses;
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (20) @(posedge clk);
    #1 rx = 1'b1;
    repeat (34) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_p54: got %0b want 1", busy); end
    @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_p55: got %0b want 0", busy); end
    repeat (200) @(posedge clk);
    #1;
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL glitch_valid: got %0b want 0", valid); end
    n_cmp++; if (err_pulses - e0 !== 0) begin n_fail++; $display("FAIL glitch_ferr: got %0d want 0", err_pulses - e0); end
  endtask

  task automatic test_frame_err();
    int e0;
    e0 = err_pulses;
    fork
      send_frame(8'h3C, 1'b0);
      begin
        @(posedge clk);
        repeat (991) @(posedge clk);
        #1;
        n_cmp++; if (ferr !== 1'b1) begin n_fail++; $display("FAIL ferr_pulse: got %0b want 1", ferr); end
        @(posedge clk);
        #1;
        n_cmp++; if (ferr !== 1'b0) begin n_fail++; $display("FAIL ferr_pulse_end: got %0b want 0", ferr); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ferr_busy_break: got %0b want 1", busy); end
      end
    join
    rx = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ferr_busy_idle: got %0b want 0", busy); end
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL ferr_no_push: got %0b want 0", valid); end
    n_cmp++; if (err_pulses - e0 !== 1) begin n_fail++; $display("FAIL ferr_count: got %0d want 1", err_pulses - e0); end
    send_frame(8'h11, 1'b1);
    n_cmp++; if (valid !== 1'b1) begin n_fail++; $display("FAIL ferr_next_valid: got %0b want 1", valid); end
    n_cmp++; if (dat !== 8'h11) begin n_fail++; $display("FAIL ferr_next_dat: got %02h want 11", dat); end
    pop_one();
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL ferr_next_drained: got %0b want 0", valid); end
  endtask

  // Line held low for three frame times: one error pulse and no bytes.
  task automatic test_break();
    int e0;
    e0 = err_pulses;
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (3 * 10 * CPB) @(posedge clk);
    #1 rx = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    n_cmp++; if (err_pulses - e0 !== 1) begin n_fail++; $display("FAIL break_count: got %0d want 1", err_pulses - e0); end
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL break_valid: got %0b want 0", valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL break_busy: got %0b want 0", busy); end
  endtask

  task automatic test_overrun();
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1);
      model_rx(8'(i), 1'b0);
    end
    n_cmp++; if (ovr !== model_ovf) begin n_fail++; $display("FAIL ovr_set: got %0b want %0b", ovr, model_ovf); end
    while (model_q.size() > 0) begin
      n_cmp++; if (valid !== 1'b1 || dat !== model_q[0]) begin
        n_fail++; $display("FAIL ovr_drain: got valid=%0b dat=%02h want valid=1 dat=%02h", valid, dat, model_q[0]);
      end
      pop_one();
      void'(model_q.pop_front());
    end
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL ovr_empty: got %0b want 0", valid); end
    n_cmp++; if (ovr !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %0b want 1", ovr); end
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    model_ovf = 1'b0;
    n_cmp++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %0b want 0", ovr); end
  endtask

  // Full FIFO with a pop landing on the push edge (P991) of 0x55.
  task automatic test_full_pop();
    logic [7:0] b;
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1);
      model_rx(b, 1'b0);
    end
    fork
      send_frame(8'h55, 1'b1);
      begin
        @(posedge clk);
        repeat (990) @(posedge clk);
        #1;
        n_cmp++; if (dat !== model_q[0]) begin n_fail++; $display("FAIL fullpop_head: got %02h want %02h", dat, model_q[0]); end
        rd = 1'b1;
        @(posedge clk);
        #1 rd = 1'b0;
      end
    join
    model_rx(8'h55, 1'b1);
    n_cmp++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL fullpop_ovr: got %0b want 0", ovr); end
    while (model_q.size() > 0) begin
      n_cmp++; if (valid !== 1'b1 || dat !== model_q[0]) begin
        n_fail++; $display("FAIL fullpop_drain: got valid=%0b dat=%02h want valid=1 dat=%02h", valid, dat, model_q[0]);
      end
      pop_one();
      void'(model_q.pop_front());
    end
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL fullpop_empty: got %0b want 0", valid); end
  endtask

  // Random bytes, idle gaps and interleaved pops against the queue model.
  task automatic test_random();
    int n;
    logic [7:0] b;
    n = $urandom_range(3, 8);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 40)) @(posedge clk);
      #1;
      b = 8'($urandom);
      send_frame(b, 1'b1);
      model_rx(b, 1'b0);
      if ($urandom_range(0, 2) == 0) begin
        n_cmp++; if (valid !== 1'b1 || dat !== model_q[0]) begin
          n_fail++; $display("FAIL rand_mid_pop: got valid=%0b dat=%02h want valid=1 dat=%02h", valid, dat, model_q[0]);
        end
        pop_one();
        void'(model_q.pop_front());
      end
    end
    n_cmp++; if (ovr !== model_ovf) begin n_fail++; $display("FAIL rand_ovr: got %0b want %0b", ovr, model_ovf); end
    while (model_q.size() > 0) begin
      n_cmp++; if (valid !== 1'b1 || dat !== model_q[0]) begin
        n_fail++; $display("FAIL rand_drain: got valid=%0b dat=%02h want valid=1 dat=%02h", valid, dat, model_q[0]);
      end
      pop_one();
      void'(model_q.pop_front());
    end
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rand_empty: got %0b want 0", valid); end
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    model_ovf = 1'b0;
  endtask

  // Reset during data bit 4 with a byte already queued: everything flushed, then 0x7E alone.
  task automatic test_mid_reset();
    int e0;
    send_frame(8'h33, 1'b1);
    @(posedge clk);
    #1;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    rx = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before: got %0b want 1", busy); end
    rst = 1'b1;
    rx  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %0b want 0", valid); end
    n_cmp++; if (dat !== 8'h00) begin n_fail++; $display("FAIL midrst_dat: got %02h want 00", dat); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %0b want 0", busy); end
    n_cmp++; if (ferr !== 1'b0) begin n_fail++; $display("FAIL midrst_ferr: got %0b want 0", ferr); end
    n_cmp++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL midrst_ovr: got %0b want 0", ovr); end
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy_after: got %0b want 0", busy); end
    e0 = err_pulses;
    send_frame(8'h7E, 1'b1);
    n_cmp++; if (valid !== 1'b1 || dat !== 8'h7E) begin
      n_fail++; $display("FAIL midrst_byte: got valid=%0b dat=%02h want valid=1 dat=7e", valid, dat);
    end
    pop_one();
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL midrst_single: got %0b want 0", valid); end
    n_cmp++; if (err_pulses - e0 !== 0) begin n_fail++; $display("FAIL midrst_ferr_count: got %0d want 0", err_pulses - e0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_break();
    test_overrun();
    test_full_pop();
    test_random();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
